// File: rtl/pc_trace_buffer_pkg.sv
// Shared definitions for the PC trace buffer: trigger FSM encoding and
// the default trace entry layout.
package trace_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int TS_W_DEF    = 16;
   localparam int ENTRY_W_DEF = XLEN_DEF + TS_W_DEF;

   typedef enum logic [1:0] {
      TR_IDLE    = 2'd0,
      TR_ARMED   = 2'd1,
      TR_CAPTURE = 2'd2,
      TR_STOPPED = 2'd3
   } tr_state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [TS_W_DEF-1:0] ts;
   } trace_entry_t;

endpackage

// File: rtl/pc_trace_buffer_if.sv
// Writeback capture and trace drain stream between the core/debug path
// and the trace buffer.
interface pc_trace_buffer_if #(
   parameter int XLEN = 32,
   parameter int TS_W = 16
) ();

   logic            wb_valid;
   logic [XLEN-1:0] wb_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [TS_W-1:0] out_ts;

   modport master (
      output wb_valid, wb_pc, out_ready,
      input  out_valid, out_pc, out_ts
   );

   modport slave (
      input  wb_valid, wb_pc, out_ready,
      output out_valid, out_pc, out_ts
   );

endinterface

// File: rtl/pc_trace_buffer_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module trace_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_r;
   logic [AW:0]  rd_ptr_r;
   logic [W-1:0] mem_r [DEPTH];
   logic         push_ok_s;
   logic         pop_ok_s;

   // Extra MSB on the pointers tells a full buffer from an empty one.
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);

   // Read/write pointer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

   // Head word, forced to zero while empty so stale data never shows.
   always_comb begin
      if (empty) begin
         dout = '0;
      end else begin
         dout = mem_r[rd_ptr_r[AW-1:0]];
      end
   end

endmodule

// File: rtl/pc_trace_buffer.sv
// Writeback PC tracer: trigger FSM, change/every filter, timestamping and
// overflow accounting in front of an FWFT trace FIFO.
module pc_trace_buffer
   import trace_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              use_trigger,
   input  logic [XLEN-1:0]   trig_start_pc,
   input  logic [XLEN-1:0]   trig_stop_pc,
   pc_trace_buffer_if.slave  trace_if,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              full,
   output logic [1:0]        state
);

   localparam int ENTRY_W = XLEN + TS_W;
   localparam logic [TS_W-1:0]   TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

   tr_state_e           state_r;
   tr_state_e           state_nxt_s;
   logic [TS_W-1:0]     ts_r;
   logic [XLEN-1:0]     last_pc_r;
   logic [DROP_W-1:0]   drop_cnt_r;
   logic                cap_s;
   logic                start_hit_s;
   logic                stop_hit_s;
   logic                filt_pass_s;
   logic                pop_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [ENTRY_W-1:0]  fifo_din_s;
   logic [ENTRY_W-1:0]  fifo_dout_s;

   assign start_hit_s = trace_if.wb_valid && (trace_if.wb_pc == trig_start_pc);
   assign stop_hit_s  = trace_if.wb_valid && (trace_if.wb_pc == trig_stop_pc);
   assign filt_pass_s = trace_if.wb_valid && (mode || (trace_if.wb_pc != last_pc_r));

   // Trigger FSM next state and capture decision; trigger hits log regardless of mode.
   always_comb begin
      state_nxt_s = state_r;
      cap_s       = 1'b0;
      if (!en) begin
         state_nxt_s = TR_IDLE;
      end else begin
         case (state_r)
            TR_IDLE: begin
               if (use_trigger) begin
                  state_nxt_s = TR_ARMED;
               end else begin
                  state_nxt_s = TR_CAPTURE;
               end
            end
            TR_ARMED: begin
               if (start_hit_s) begin
                  state_nxt_s = TR_CAPTURE;
                  cap_s       = 1'b1;
               end else begin
                  state_nxt_s = TR_ARMED;
               end
            end
            TR_CAPTURE: begin
               if (use_trigger && stop_hit_s) begin
                  state_nxt_s = TR_STOPPED;
                  cap_s       = 1'b1;
               end else begin
                  state_nxt_s = TR_CAPTURE;
                  cap_s       = filt_pass_s;
               end
            end
            TR_STOPPED: begin
               state_nxt_s = TR_STOPPED;
            end
            default: begin
               state_nxt_s = TR_IDLE;
            end
         endcase
      end
   end

   // State, timestamp and last-seen PC registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= TR_IDLE;
         ts_r      <= '0;
         last_pc_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         ts_r    <= ts_r + TS_ONE;
         if (en && trace_if.wb_valid) begin
            last_pc_r <= trace_if.wb_pc;
         end
      end
   end

   assign pop_s      = !fifo_empty_s && trace_if.out_ready;
   assign fifo_din_s = {trace_if.wb_pc, ts_r};

   // Saturating count of captures lost to a full FIFO with no pop to make room.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_r <= '0;
      end else begin
         if (cap_s && fifo_full_s && !pop_s && (drop_cnt_r != '1)) begin
            drop_cnt_r <= drop_cnt_r + DROP_ONE;
         end
      end
   end

   trace_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap_s),
      .pop   (pop_s),
      .din   (fifo_din_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign trace_if.out_valid = !fifo_empty_s;
   assign trace_if.out_pc    = fifo_dout_s[ENTRY_W-1:TS_W];
   assign trace_if.out_ts    = fifo_dout_s[TS_W-1:0];
   assign drop_cnt           = drop_cnt_r;
   assign full               = fifo_full_s;
   assign state              = state_r;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer: directed trace scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_pc_trace_buffer;

   localparam int XLEN   = 32;
   localparam int DEPTH  = 16;
   localparam int TS_W   = 16;
   localparam int DROP_W = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [15:0] ts;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en = 1'b0;
   logic              mode = 1'b0;
   logic              use_trigger = 1'b0;
   logic [XLEN-1:0]   trig_start_pc = 32'h0;
   logic [XLEN-1:0]   trig_stop_pc = 32'h0;
   logic [DROP_W-1:0] drop_cnt;
   logic              full;
   logic [1:0]        state;

   pc_trace_buffer_if #(.XLEN(XLEN), .TS_W(TS_W)) bus ();

   pc_trace_buffer #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .TS_W   (TS_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .mode          (mode),
      .use_trigger   (use_trigger),
      .trig_start_pc (trig_start_pc),
      .trig_stop_pc  (trig_stop_pc),
      .trace_if      (bus),
      .drop_cnt      (drop_cnt),
      .full          (full),
      .state         (state)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   ent_t        m_q[$];
   ent_t        seen_q[$];
   int          m_state;
   logic [31:0] m_last;
   logic [15:0] m_ts;
   int unsigned m_drop;
   logic [31:0] seq[5] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
   logic [31:0] pool[7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_state = 0;
      m_last  = 32'h0;
      m_ts    = 16'h0;
      m_drop  = 0;
   endtask

   task automatic check_outputs();
      check_eq("out_valid", bus.out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         check_eq("out_pc", bus.out_pc, m_q[0].pc);
         check_eq("out_ts", bus.out_ts, m_q[0].ts);
      end
      check_eq("full", full, m_q.size() == DEPTH);
      check_eq("drop_cnt", drop_cnt, m_drop);
      check_eq("state", state, m_state);
   endtask

   // One clock: predict from the current inputs, advance, then compare.
   task automatic tick();
      bit pop;
      bit cap;
      int nxt;
      pop = (m_q.size() > 0) && bus.out_ready;
      if (bus.out_valid && bus.out_ready) seen_q.push_back('{pc: bus.out_pc, ts: bus.out_ts});
      cap = 1'b0;
      nxt = m_state;
      if (!en) begin
         nxt = 0;
      end else begin
         case (m_state)
            0: nxt = use_trigger ? 1 : 2;
            1: if (bus.wb_valid && bus.wb_pc == trig_start_pc) begin cap = 1'b1; nxt = 2; end
            2: begin
               if (use_trigger && bus.wb_valid && bus.wb_pc == trig_stop_pc) begin
                  cap = 1'b1;
                  nxt = 3;
               end else begin
                  cap = bus.wb_valid && (mode || bus.wb_pc != m_last);
               end
            end
            default: nxt = 3;
         endcase
      end
      if (pop) void'(m_q.pop_front());
      if (cap) begin
         if (m_q.size() < DEPTH) m_q.push_back('{pc: bus.wb_pc, ts: m_ts});
         else if (m_drop < 65535) m_drop++;
      end
      if (en && bus.wb_valid) m_last = bus.wb_pc;
      m_state = nxt;
      m_ts    = m_ts + 16'd1;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic wb(input bit v, input logic [31:0] pc);
      bus.wb_valid = v;
      bus.wb_pc    = pc;
      tick();
   endtask

   // Asynchronous reset between edges, checked before any clock edge arrives.
   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      check_eq("rst_out_valid", bus.out_valid, 1'b0);
      check_eq("rst_out_pc", bus.out_pc, 32'h0);
      check_eq("rst_out_ts", bus.out_ts, 16'h0);
      check_eq("rst_drop_cnt", drop_cnt, 16'h0);
      check_eq("rst_full", full, 1'b0);
      check_eq("rst_state", state, 2'd0);
      model_reset();
      seen_q.delete();
      en = 1'b0;
      bus.wb_valid = 1'b0;
      bus.wb_pc = 32'h0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bus.wb_valid  = 1'b0;
      bus.wb_pc     = 32'h0;
      bus.out_ready = 1'b0;

      // Change mode without trigger.
      do_reset();
      en = 1'b1; mode = 1'b0; use_trigger = 1'b0; bus.out_ready = 1'b1;
      wb(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) wb(1'b1, seq[i]);
      wb(1'b0, 32'h0);
      wb(1'b0, 32'h0);
      check_eq("chg_count", seen_q.size(), 2);
      if (seen_q.size() >= 2) begin
         check_eq("chg_pc0", seen_q[0].pc, 32'h4);
         check_eq("chg_pc1", seen_q[1].pc, 32'h8);
         check_eq("chg_ts_gap", seen_q[1].ts - seen_q[0].ts, 16'd2);
      end

      // Every-writeback mode.
      do_reset();
      en = 1'b1; mode = 1'b1; bus.out_ready = 1'b1;
      wb(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) wb(1'b1, seq[i]);
      wb(1'b0, 32'h0);
      wb(1'b0, 32'h0);
      check_eq("every_count", seen_q.size(), 5);
      if (seen_q.size() >= 5) begin
         for (int i = 0; i < 5; i++) check_eq("every_pc", seen_q[i].pc, seq[i]);
         for (int i = 1; i < 5; i++) check_eq("every_ts_step", seen_q[i].ts - seen_q[i-1].ts, 16'd1);
      end

      // Start/stop trigger window.
      do_reset();
      en = 1'b1; mode = 1'b0; use_trigger = 1'b1; bus.out_ready = 1'b1;
      trig_start_pc = 32'h10; trig_stop_pc = 32'h20;
      wb(1'b0, 32'h0);
      for (int i = 0; i <= 12; i++) wb(1'b1, 32'(i * 4));
      wb(1'b0, 32'h0);
      wb(1'b0, 32'h0);
      check_eq("trig_count", seen_q.size(), 5);
      if (seen_q.size() >= 5) begin
         for (int i = 0; i < 5; i++) check_eq("trig_pc", seen_q[i].pc, 32'(32'h10 + i * 4));
      end
      check_eq("trig_state", state, 2'd3);

      // Overflow, then a push into a full FIFO alongside a pop, then drain.
      do_reset();
      en = 1'b1; mode = 1'b1; use_trigger = 1'b0; bus.out_ready = 1'b0;
      wb(1'b0, 32'h0);
      for (int i = 0; i < 20; i++) wb(1'b1, 32'(32'h100 + i * 4));
      check_eq("ovf_full", full, 1'b1);
      check_eq("ovf_drop", drop_cnt, 16'd4);
      bus.out_ready = 1'b1;
      wb(1'b1, 32'h200);
      check_eq("fullpop_drop", drop_cnt, 16'd4);
      check_eq("fullpop_full", full, 1'b1);
      for (int i = 0; i < 17; i++) wb(1'b0, 32'h0);
      check_eq("drain_count", seen_q.size(), 17);
      if (seen_q.size() >= 17) begin
         for (int i = 0; i < 16; i++) check_eq("drain_pc", seen_q[i].pc, 32'(32'h100 + i * 4));
         check_eq("drain_last", seen_q[16].pc, 32'h200);
      end

      // Asynchronous reset with entries queued.
      do_reset();
      en = 1'b1; mode = 1'b1; bus.out_ready = 1'b0;
      wb(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) wb(1'b1, 32'(32'h40 + i * 4));
      check_eq("pre_rst_valid", bus.out_valid, 1'b1);
      do_reset();
      en = 1'b1; mode = 1'b1;
      wb(1'b0, 32'h0);
      wb(1'b1, 32'h80);
      check_eq("post_rst_pc", bus.out_pc, 32'h80);
      check_eq("post_rst_ts", bus.out_ts, 16'd1);

      // Randomized traffic against the model.
      do_reset();
      trig_start_pc = 32'h10; trig_stop_pc = 32'h20;
      for (int c = 0; c < 800; c++) begin
         if (c % 60 == 0) begin
            mode        = 1'($urandom_range(0, 1));
            use_trigger = 1'($urandom_range(0, 1));
         end
         en            = ($urandom_range(0, 24) != 0);
         bus.out_ready = ($urandom_range(0, 9) < 4);
         bus.wb_valid  = en && ($urandom_range(0, 9) < 7);
         bus.wb_pc     = pool[$urandom_range(0, 6)];
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
